// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Streams a program image into instruction memory through the
//            external port. It then reads the image back and checksums it,
//            and enables the CPU only when both checksums agree.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
   parameter int          ADDR_W    = 9,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic [63:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   input  logic [31:0]       rdata_ext,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [ADDR_W:0]   word_count
);

   // Capacity in words; word_count is one bit wider so it can hold DEPTH itself
   localparam logic [ADDR_W:0] c_DEPTH        = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [1:0]      c_ERR_NONE     = 2'b00;
   localparam logic [1:0]      c_ERR_OVERFLOW = 2'b01;
   localparam logic [1:0]      c_ERR_CHECKSUM = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_CHECK  = 3'd3,
      ST_RUN    = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_word_count, w_wc_nxt;
   logic [ADDR_W:0]   r_rd_idx, w_rd_idx_nxt;
   logic [31:0]       r_wsum, w_wsum_nxt;
   logic [31:0]       r_rsum, w_rsum_nxt;
   logic              r_rd_pend, w_rd_pend_nxt;
   logic              r_s_ready, w_sready_nxt;
   logic [63:0]       r_addr, w_addr_nxt;
   logic              r_wen, w_wen_nxt;
   logic              r_ren, w_ren_nxt;
   logic [31:0]       r_wdata, w_wdata_nxt;
   logic              r_cpu_en, w_cpu_en_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic [1:0]        r_err, w_err_nxt;

   logic [63:0]       w_wr_addr;
   logic [63:0]       w_rd_addr;
   logic [31:0]       w_rsum_acc;

   // Byte addresses of the next write and next read-back word
   assign w_wr_addr  = BASE_ADDR + 64'({r_word_count, 2'b00});
   assign w_rd_addr  = BASE_ADDR + 64'({r_rd_idx, 2'b00});
   // Read data lands one cycle after its request; fold it in when it arrives
   assign w_rsum_acc = r_rd_pend ? (r_rsum + rdata_ext) : r_rsum;

   // Next-state and next-output decode; every output is registered below
   always_comb begin
      w_state_nxt   = r_state;
      w_wc_nxt      = r_word_count;
      w_rd_idx_nxt  = r_rd_idx;
      w_wsum_nxt    = r_wsum;
      w_rsum_nxt    = w_rsum_acc;
      w_rd_pend_nxt = r_ren;
      w_sready_nxt  = r_s_ready;
      w_addr_nxt    = r_addr;
      w_wen_nxt     = 1'b0;
      w_ren_nxt     = 1'b0;
      w_wdata_nxt   = r_wdata;
      w_cpu_en_nxt  = r_cpu_en;
      w_busy_nxt    = r_busy;
      w_done_nxt    = r_done;
      w_err_nxt     = r_err;
      case (r_state)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (start) begin
               w_state_nxt   = ST_LOAD;
               w_wc_nxt      = '0;
               w_rd_idx_nxt  = '0;
               w_wsum_nxt    = 32'h0;
               w_rsum_nxt    = 32'h0;
               w_rd_pend_nxt = 1'b0;
               w_sready_nxt  = 1'b1;
               w_cpu_en_nxt  = 1'b0;
               w_busy_nxt    = 1'b1;
               w_done_nxt    = 1'b0;
               w_err_nxt     = c_ERR_NONE;
            end
         end
         ST_LOAD: begin
            if (s_valid && r_s_ready) begin
               if (r_word_count < c_DEPTH) begin
                  w_wen_nxt   = 1'b1;
                  w_addr_nxt  = w_wr_addr;
                  w_wdata_nxt = s_data;
                  w_wc_nxt    = r_word_count + 1'b1;
                  w_wsum_nxt  = r_wsum + s_data;
                  if (s_last) begin
                     w_state_nxt  = ST_VERIFY;
                     w_sready_nxt = 1'b0;
                  end
               end else begin
                  // Beat beyond capacity: dropped, image rejected
                  w_state_nxt  = ST_ERROR;
                  w_sready_nxt = 1'b0;
                  w_busy_nxt   = 1'b0;
                  w_err_nxt    = c_ERR_OVERFLOW;
               end
            end
         end
         ST_VERIFY: begin
            // First VERIFY cycle still shows the final write, so reads trail by one
            if (r_rd_idx < r_word_count) begin
               w_ren_nxt    = 1'b1;
               w_addr_nxt   = w_rd_addr;
               w_rd_idx_nxt = r_rd_idx + 1'b1;
            end else begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_busy_nxt = 1'b0;
            if (w_rsum_acc == r_wsum) begin
               w_state_nxt  = ST_RUN;
               w_cpu_en_nxt = 1'b1;
               w_done_nxt   = 1'b1;
            end else begin
               w_state_nxt = ST_ERROR;
               w_err_nxt   = c_ERR_CHECKSUM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters, checksums and output registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state      <= ST_IDLE;
         r_word_count <= '0;
         r_rd_idx     <= '0;
         r_wsum       <= 32'h0;
         r_rsum       <= 32'h0;
         r_rd_pend    <= 1'b0;
         r_s_ready    <= 1'b0;
         r_addr       <= 64'h0;
         r_wen        <= 1'b0;
         r_ren        <= 1'b0;
         r_wdata      <= 32'h0;
         r_cpu_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= c_ERR_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_word_count <= w_wc_nxt;
         r_rd_idx     <= w_rd_idx_nxt;
         r_wsum       <= w_wsum_nxt;
         r_rsum       <= w_rsum_nxt;
         r_rd_pend    <= w_rd_pend_nxt;
         r_s_ready    <= w_sready_nxt;
         r_addr       <= w_addr_nxt;
         r_wen        <= w_wen_nxt;
         r_ren        <= w_ren_nxt;
         r_wdata      <= w_wdata_nxt;
         r_cpu_en     <= w_cpu_en_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
      end
   end

   assign s_ready    = r_s_ready;
   assign addr_ext   = r_addr;
   assign wen_ext    = r_wen;
   assign ren_ext    = r_ren;
   assign wdata_ext  = r_wdata;
   assign cpu_enable = r_cpu_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader. Instance a has
//            ADDR_W=9/BASE 0, instance b has ADDR_W=2/BASE 0x100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst_n  [2];
   logic        start   [2];
   logic        s_valid [2];
   logic        s_last  [2];
   logic [31:0] s_data  [2];
   logic        s_ready [2];
   logic        wen     [2];
   logic        ren     [2];
   logic        cpu_en  [2];
   logic        busy    [2];
   logic        done    [2];
   logic [63:0] addr    [2];
   logic [31:0] wdata   [2];
   logic [31:0] rdata   [2];
   logic [1:0]  err     [2];
   logic [9:0]  wc_a;
   logic [2:0]  wc_b;

   imem_boot_loader #(.ADDR_W(9), .BASE_ADDR(64'h0)) u_dut_a (
      .clk(clk), .arst_n(arst_n[0]), .start(start[0]), .s_valid(s_valid[0]),
      .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
      .addr_ext(addr[0]), .wen_ext(wen[0]), .ren_ext(ren[0]), .wdata_ext(wdata[0]),
      .rdata_ext(rdata[0]), .cpu_enable(cpu_en[0]), .busy(busy[0]), .done(done[0]),
      .err(err[0]), .word_count(wc_a));

   imem_boot_loader #(.ADDR_W(2), .BASE_ADDR(64'h100)) u_dut_b (
      .clk(clk), .arst_n(arst_n[1]), .start(start[1]), .s_valid(s_valid[1]),
      .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
      .addr_ext(addr[1]), .wen_ext(wen[1]), .ren_ext(ren[1]), .wdata_ext(wdata[1]),
      .rdata_ext(rdata[1]), .cpu_enable(cpu_en[1]), .busy(busy[1]), .done(done[1]),
      .err(err[1]), .word_count(wc_b));

   // Instruction memory models; corrupt flips bit 0 of reads from byte address 0x8
   logic [31:0] mem [2][1024];
   bit          corrupt [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (wen[d]) mem[d][addr[d][11:2]] <= wdata[d];
         if (ren[d]) rdata[d] <= mem[d][addr[d][11:2]] ^ ((corrupt[d] && addr[d] == 64'h8) ? 32'h1 : 32'h0);
      end
   end

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct { int d; logic [63:0] a; int c; } wr_t;
   wr_t wlog[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int depth(input int d);
      return (d == 0) ? 512 : 4;
   endfunction

   function automatic logic [63:0] base(input int d);
      return (d == 0) ? 64'h0 : 64'h100;
   endfunction

   function automatic logic [63:0] wc_of(input int d);
      return (d == 0) ? 64'(wc_a) : 64'(wc_b);
   endfunction

   // Reference model: phase 0 idle, 1 loading, 2 read-back/check, 3 running, 4 error.
   // Read-back timing is derived from the cycle the first VERIFY cycle starts.
   int          m_ph    [2];
   int          m_wc    [2];
   int          m_v0    [2];
   logic [31:0] m_words [2][512];
   logic        e_sready[2], e_wen[2], e_ren[2], e_busy[2], e_done[2], e_cpu[2];
   logic [1:0]  e_err   [2];
   logic [63:0] e_addr  [2];
   logic [31:0] e_wdata [2];

   task automatic model_reset(input int d);
      m_ph[d] = 0; m_wc[d] = 0; m_v0[d] = 0;
      e_sready[d] = 0; e_wen[d] = 0; e_ren[d] = 0; e_busy[d] = 0;
      e_done[d] = 0; e_cpu[d] = 0; e_err[d] = 0; e_addr[d] = 0; e_wdata[d] = 0;
   endtask

   task automatic compare(input int d);
      string p;
      p = (d == 0) ? "a" : "b";
      chk({p, " s_ready"},    64'(s_ready[d]), 64'(e_sready[d]));
      chk({p, " wen_ext"},    64'(wen[d]),     64'(e_wen[d]));
      chk({p, " ren_ext"},    64'(ren[d]),     64'(e_ren[d]));
      chk({p, " addr_ext"},   addr[d],         e_addr[d]);
      chk({p, " busy"},       64'(busy[d]),    64'(e_busy[d]));
      chk({p, " done"},       64'(done[d]),    64'(e_done[d]));
      chk({p, " cpu_enable"}, 64'(cpu_en[d]),  64'(e_cpu[d]));
      chk({p, " err"},        64'(err[d]),     64'(e_err[d]));
      chk({p, " word_count"}, wc_of(d),        64'(m_wc[d]));
      chk({p, " ren&wen"},    64'(ren[d] & wen[d]), 64'(0));
      if (e_wen[d]) chk({p, " wdata_ext"}, 64'(wdata[d]), 64'(e_wdata[d]));
   endtask

   task automatic model_step(input int d);
      int          n;
      logic [31:0] ws, rs;
      e_wen[d] = 0;
      e_ren[d] = 0;
      case (m_ph[d])
         0, 3, 4: begin
            if (start[d]) begin
               m_ph[d] = 1; m_wc[d] = 0;
               e_sready[d] = 1; e_busy[d] = 1; e_done[d] = 0; e_cpu[d] = 0; e_err[d] = 0;
            end
         end
         1: begin
            if (s_valid[d] && e_sready[d]) begin
               if (m_wc[d] < depth(d)) begin
                  e_wen[d]   = 1;
                  e_addr[d]  = base(d) + 64'(4 * m_wc[d]);
                  e_wdata[d] = s_data[d];
                  m_words[d][m_wc[d]] = s_data[d];
                  m_wc[d]++;
                  if (s_last[d]) begin
                     m_ph[d] = 2; e_sready[d] = 0; m_v0[d] = cyc + 1;
                  end
               end else begin
                  m_ph[d] = 4; e_err[d] = 2'b01; e_busy[d] = 0; e_sready[d] = 0;
               end
            end
         end
         2: begin
            n = cyc + 1 - m_v0[d];
            if (n >= 1 && n <= m_wc[d]) begin
               e_ren[d]  = 1;
               e_addr[d] = base(d) + 64'(4 * (n - 1));
            end else if (n == m_wc[d] + 2) begin
               ws = 0; rs = 0;
               for (int i = 0; i < m_wc[d]; i++) begin
                  ws += m_words[d][i];
                  rs += m_words[d][i] ^ ((corrupt[d] && base(d) + 64'(4 * i) == 64'h8) ? 32'h1 : 32'h0);
               end
               e_busy[d] = 0;
               if (ws == rs) begin
                  m_ph[d] = 3; e_done[d] = 1; e_cpu[d] = 1;
               end else begin
                  m_ph[d] = 4; e_err[d] = 2'b10;
               end
            end
         end
         default: ;
      endcase
   endtask

   // Compare DUT outputs against the model every cycle, then advance the model
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (!arst_n[d]) begin
            model_reset(d);
            compare(d);
         end else begin
            compare(d);
            if (wen[d]) wlog.push_back('{d, addr[d], cyc});
            model_step(d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1;
      tick();
      start[d] = 0;
   endtask

   task automatic send(input int d, input logic [31:0] w, input logic last, input int gap);
      bit ok;
      ok = 0;
      s_valid[d] = 1; s_data[d] = w; s_last[d] = last;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (s_ready[d]) ok = 1;
         tick();
      end
      s_valid[d] = 0; s_last[d] = 0;
      chk("beat accepted", 64'(ok), 64'(1));
      repeat (gap) tick();
   endtask

   task automatic wait_end(input int d);
      bit ok;
      ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         if (done[d] || err[d] != 2'b00) ok = 1;
         else tick();
      end
      chk("load finished in time", 64'(ok), 64'(1));
   endtask

   task automatic check_writes(input int d, input int idx, input int n_exp,
                               input logic [63:0] a_first, input int span_exp);
      wr_t q[$];
      for (int i = idx; i < wlog.size(); i++) if (wlog[i].d == d) q.push_back(wlog[i]);
      chk("write count", 64'(q.size()), 64'(n_exp));
      if (q.size() == n_exp && n_exp > 0) begin
         for (int k = 0; k < n_exp; k++) chk("write addr", q[k].a, a_first + 64'(4 * k));
         chk("write span", 64'(q[n_exp - 1].c - q[0].c), 64'(span_exp));
      end
   endtask

   logic [31:0] img [4];
   int          idx;

   initial begin
      img[0] = 32'h00500093; img[1] = 32'h00A00113;
      img[2] = 32'h002081B3; img[3] = 32'h00000013;
      for (int d = 0; d < 2; d++) begin
         arst_n[d] = 0; start[d] = 0; s_valid[d] = 0; s_last[d] = 0; s_data[d] = 0; corrupt[d] = 0;
      end
      repeat (3) tick();
      chk("reset done",       64'(done[0]),   64'(0));
      chk("reset cpu_enable", 64'(cpu_en[0]), 64'(0));
      chk("reset addr_ext",   addr[0],        64'h0);
      arst_n[0] = 1; arst_n[1] = 1;
      tick();

      // Nominal back-to-back 4-word load
      idx = wlog.size();
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(0, img[i], i == 3, 0);
      wait_end(0);
      chk("nominal done",       64'(done[0]),   64'(1));
      chk("nominal cpu_enable", 64'(cpu_en[0]), 64'(1));
      chk("nominal word_count", 64'(wc_a),      64'(4));
      chk("nominal err",        64'(err[0]),    64'(0));
      chk("nominal mem[2]",     64'(mem[0][2]), 64'h002081B3);
      check_writes(0, idx, 4, 64'h0, 3);

      // Throttled stream, restarted from RUN
      idx = wlog.size();
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(0, img[i], i == 3, (i == 3) ? 0 : 2);
      wait_end(0);
      chk("throttled done",       64'(done[0]), 64'(1));
      chk("throttled word_count", 64'(wc_a),    64'(4));
      check_writes(0, idx, 4, 64'h0, 9);

      // Checksum fault on read of 0x8
      corrupt[0] = 1;
      pulse_start(0);
      for (int i = 0; i < 4; i++) send(0, img[i], i == 3, 0);
      wait_end(0);
      chk("fault err",        64'(err[0]),    64'(2));
      chk("fault cpu_enable", 64'(cpu_en[0]), 64'(0));
      chk("fault done",       64'(done[0]),   64'(0));
      tick();
      corrupt[0] = 0;

      // Reset mid-LOAD, then a 1-word image
      pulse_start(0);
      send(0, 32'hDEADBEEF, 0, 0);
      send(0, 32'hCAFEF00D, 0, 0);
      #2 arst_n[0] = 0;
      #1;
      chk("async rst busy",       64'(busy[0]),    64'(0));
      chk("async rst s_ready",    64'(s_ready[0]), 64'(0));
      chk("async rst wen_ext",    64'(wen[0]),     64'(0));
      chk("async rst addr_ext",   addr[0],         64'h0);
      chk("async rst word_count", 64'(wc_a),       64'(0));
      tick();
      arst_n[0] = 1;
      tick();
      pulse_start(0);
      send(0, 32'h12345678, 1, 0);
      wait_end(0);
      chk("1-word done",       64'(done[0]), 64'(1));
      chk("1-word word_count", 64'(wc_a),    64'(1));

      // Overflow on the DEPTH=4 instance
      idx = wlog.size();
      pulse_start(1);
      for (int i = 0; i < 5; i++) send(1, 32'h1000 + 32'(i), i == 4, 0);
      wait_end(1);
      chk("overflow err",        64'(err[1]),    64'(1));
      chk("overflow word_count", 64'(wc_b),      64'(4));
      chk("overflow cpu_enable", 64'(cpu_en[1]), 64'(0));
      check_writes(1, idx, 4, 64'h100, 3);

      // Reload from RUN, with a start pulse during VERIFY ignored
      pulse_start(1);
      send(1, 32'h11111111, 0, 0);
      send(1, 32'h22222222, 1, 0);
      wait_end(1);
      chk("pre-reload done", 64'(done[1]), 64'(1));
      idx = wlog.size();
      pulse_start(1);
      chk("reload cpu_enable drop", 64'(cpu_en[1]), 64'(0));
      send(1, 32'hA0A0A0A0, 0, 0);
      send(1, 32'hB1B1B1B1, 0, 0);
      send(1, 32'hC2C2C2C2, 1, 0);
      tick();
      pulse_start(1);
      chk("verify start ignored busy", 64'(busy[1]), 64'(1));
      wait_end(1);
      chk("reload done",       64'(done[1]), 64'(1));
      chk("reload word_count", 64'(wc_b),    64'(3));
      check_writes(1, idx, 3, 64'h100, 2);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
